// File: rtl/fft_block_loader_if.sv
// Sample-stream bundle between a complex Q1.15 source and the block loader.
// The source drives the sample and its framing; the loader returns s_ready.
interface fft_block_loader_if;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_re;
  logic signed [15:0] s_im;
  logic               s_last;
  logic [2:0]         stage;

  modport master (output s_valid, s_re, s_im, s_last, stage, input s_ready);
  modport slave  (input s_valid, s_re, s_im, s_last, stage, output s_ready);
endinterface

// File: rtl/fft_block_loader.sv
// Packs a serial complex sample stream into 8-lane blocks for the twiddle
// multiplier and attaches each block's twiddle start/step for the frame's stage.
module fft_block_loader #(
  parameter int N_POINTS = 64,
  parameter int LANES    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_block_loader_if.slave  s,
  output logic               isValid,
  output logic [5:0]         start,
  output logic [5:0]         step,
  output logic signed [15:0] x  [LANES],
  output logic signed [15:0] xi [LANES],
  output logic               frame_err
);

  localparam logic [5:0] LAST_CNT = 6'(N_POINTS - 1);
  localparam logic [2:0] LAST_LANE = 3'(LANES - 1);

  typedef enum logic [0:0] {FILL = 1'b0, PAD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [2:0]         lane_q, lane_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2:0]         stage_q, stage_d;
  logic signed [15:0] bank_re_q [LANES];
  logic signed [15:0] bank_im_q [LANES];
  logic signed [15:0] x_q  [LANES];
  logic signed [15:0] xi_q [LANES];
  logic               valid_q, err_q;
  logic [5:0]         start_q, step_q;

  logic       acc_s, emit_s, short_s, miss_s;
  logic [2:0] stage_in_s, blk_stage_s;
  logic [5:0] blk_base_s, start_s, step_s;

  // Handshake decode, emit triggers and twiddle arithmetic for the current sample
  always_comb begin
    acc_s      = s.s_valid && ready_q;
    stage_in_s = (s.stage > 3'd5) ? 3'd5 : s.stage;
    // The frame's first sample carries the stage that this block must use
    blk_stage_s = (cnt_q == 6'd0) ? stage_in_s : stage_q;
    emit_s     = acc_s && ((lane_q == LAST_LANE) || s.s_last);
    short_s    = emit_s && s.s_last && (cnt_q != LAST_CNT);
    miss_s     = emit_s && !s.s_last && (cnt_q == LAST_CNT);
    blk_base_s = {cnt_q[5:3], 3'b000};
    start_s    = blk_base_s << blk_stage_s;
    step_s     = 6'd1 << blk_stage_s;
  end

  // Next-state logic for the fill/pad sequencer and frame counters
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    case (state_q)
      FILL: begin
        if (acc_s) begin
          if (cnt_q == 6'd0) begin
            stage_d = stage_in_s;
          end else begin
            stage_d = stage_q;
          end
          if (emit_s && s.s_last) begin
            cnt_d   = 6'd0;
            lane_d  = 3'd0;
            state_d = short_s ? PAD : FILL;
          end else if (cnt_q == LAST_CNT) begin
            cnt_d  = 6'd0;
            lane_d = 3'd0;
          end else begin
            cnt_d  = cnt_q + 6'd1;
            lane_d = lane_q + 3'd1;
          end
        end else begin
          state_d = FILL;
        end
      end
      PAD:     state_d = FILL;
      default: state_d = FILL;
    endcase
    ready_d = (state_d == FILL);
  end

  // Sequencer and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      ready_q <= 1'b0;
      lane_q  <= 3'd0;
      cnt_q   <= 6'd0;
      stage_q <= 3'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  // Sample bank and block output registers; lanes past the accepted one are zeroed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < LANES; j++) begin
        bank_re_q[j] <= 16'sd0;
        bank_im_q[j] <= 16'sd0;
        x_q[j]       <= 16'sd0;
        xi_q[j]      <= 16'sd0;
      end
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 6'd0;
      step_q  <= 6'd0;
    end else begin
      valid_q <= emit_s;
      err_q   <= short_s || miss_s;
      if (acc_s) begin
        bank_re_q[lane_q] <= s.s_re;
        bank_im_q[lane_q] <= s.s_im;
      end
      if (emit_s) begin
        start_q <= start_s;
        step_q  <= step_s;
        for (int j = 0; j < LANES; j++) begin
          if (3'(j) < lane_q) begin
            x_q[j]  <= bank_re_q[j];
            xi_q[j] <= bank_im_q[j];
          end else if (3'(j) == lane_q) begin
            x_q[j]  <= s.s_re;
            xi_q[j] <= s.s_im;
          end else begin
            x_q[j]  <= 16'sd0;
            xi_q[j] <= 16'sd0;
          end
        end
      end
    end
  end

  assign s.s_ready = ready_q;
  assign isValid   = valid_q;
  assign frame_err = err_q;
  assign start     = start_q;
  assign step      = step_q;
  assign x         = x_q;
  assign xi        = xi_q;

endmodule

// File: tb/tb_fft_block_loader.sv
// Directed bench for fft_block_loader: a table of blocks with hand-computed
// twiddle/error expectations plus hand sequences for reset and pad timing.
module tb_fft_block_loader;

  logic               clk;
  logic               rst_n;
  logic               isValid;
  logic [5:0]         start;
  logic [5:0]         step;
  logic signed [15:0] x  [8];
  logic signed [15:0] xi [8];
  logic               frame_err;

  fft_block_loader_if sif ();

  fft_block_loader #(.N_POINTS(64), .LANES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (sif.slave),
    .isValid   (isValid),
    .start     (start),
    .step      (step),
    .x         (x),
    .xi        (xi),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         base;
    int         nval;
    logic       last;
    logic [2:0] stg;
    logic       gap;
    logic [5:0] exp_start;
    logic [5:0] exp_step;
    logic       exp_err;
  } blk_t;

  blk_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Present one sample and return 1 time unit after the edge that accepts it
  task automatic send(input int v, input logic last, input logic [2:0] stg);
    int t;
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_re    = 16'(v);
    sif.s_im    = 16'(-v);
    sif.s_last  = last;
    sif.stage   = stg;
    t = 0;
    while (!sif.s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!sif.s_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got s_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_blk(input int idx, input blk_t b);
    for (int j = 0; j < b.nval; j++) begin
      send(b.base + j, b.last && (j == b.nval - 1), b.stg);
      if (j != b.nval - 1) begin
        chk($sformatf("blk%0d_s%0d_valid", idx, j), {isValid, frame_err}, 2'b00);
        if (b.gap) begin
          idle_cycle();
          chk($sformatf("blk%0d_gap%0d_valid", idx, j), isValid, 0);
        end
      end
    end
    chk($sformatf("blk%0d_valid", idx), isValid, 1);
    chk($sformatf("blk%0d_err", idx), frame_err, b.exp_err);
    chk($sformatf("blk%0d_start", idx), start, b.exp_start);
    chk($sformatf("blk%0d_step", idx), step, b.exp_step);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("blk%0d_x%0d", idx, j), x[j], (j < b.nval) ? (b.base + j) : 0);
      chk($sformatf("blk%0d_xi%0d", idx, j), xi[j], (j < b.nval) ? -(b.base + j) : 0);
    end
    if (b.last && b.exp_err) begin
      chk($sformatf("blk%0d_pad_ready", idx), sif.s_ready, 0);
      idle_cycle();
      chk($sformatf("blk%0d_after_pad_ready", idx), sif.s_ready, 1);
      chk($sformatf("blk%0d_after_pad_pulse", idx), {isValid, frame_err}, 2'b00);
    end else if (b.last) begin
      chk($sformatf("blk%0d_end_ready", idx), sif.s_ready, 1);
    end else begin
      chk($sformatf("blk%0d_ready", idx), sif.s_ready, 1);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, isValid, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_ready"}, sif.s_ready, 0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("%s_x%0d", tag, j), x[j], 0);
      chk($sformatf("%s_xi%0d", tag, j), xi[j], 0);
    end
  endtask

  initial begin
    logic [5:0] starts_b [8];
    logic [5:0] starts_m [8];
    blk_t       rb;

    // Frame A: stage 0, 64 samples, s_last on sample 63
    for (int b = 0; b < 8; b++)
      tbl.push_back('{8*b, 8, (b == 7), 3'd0, 1'b0, 6'(8*b), 6'd1, 1'b0});
    // Frame B: stage 2, block 3 fed with s_valid toggling
    starts_b = '{6'd0, 6'd32, 6'd0, 6'd32, 6'd0, 6'd32, 6'd0, 6'd32};
    for (int b = 0; b < 8; b++)
      tbl.push_back('{8*b, 8, (b == 7), 3'd2, (b == 3), starts_b[b], 6'd4, 1'b0});
    // Short frame: s_last on sample 10
    tbl.push_back('{0, 8, 1'b0, 3'd0, 1'b0, 6'd0, 6'd1, 1'b0});
    tbl.push_back('{8, 3, 1'b1, 3'd0, 1'b0, 6'd8, 6'd1, 1'b1});
    // Missing s_last: stage 1, 64 samples without s_last
    starts_m = '{6'd0, 6'd16, 6'd32, 6'd48, 6'd0, 6'd16, 6'd32, 6'd48};
    for (int b = 0; b < 8; b++)
      tbl.push_back('{100 + 8*b, 8, 1'b0, 3'd1, 1'b0, starts_m[b], 6'd2, (b == 7)});
    // Sample 64 after the wrap starts a new frame; stage 6 saturates to 5
    tbl.push_back('{200, 8, 1'b0, 3'd6, 1'b0, 6'd0, 6'd32, 1'b0});

    rst_n       = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_re    = 16'sd0;
    sif.s_im    = 16'sd0;
    sif.s_last  = 1'b0;
    sif.stage   = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply_blk(i, tbl[i]);

    // Reset after lane 4: partial block is dropped, outputs clear at once
    for (int j = 0; j < 5; j++) begin
      send(300 + j, 1'b0, 3'd3);
      chk($sformatf("partial_s%0d_valid", j), isValid, 0);
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", isValid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rb = '{400, 8, 1'b0, 3'd0, 1'b0, 6'd0, 6'd1, 1'b0};
    apply_blk(99, rb);
    idle_cycle();
    chk("final_valid_drop", isValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
